// File: rtl/axi_slave_regbank.sv
// AXI-style slave register bank: one burst in flight, byte-strobed word array, sticky/per-beat responses.
// Optional macro AXI_SLAVE_WRAP_BURST_EN enables WRAP bursts for LEN 1/3/7/15.
module axi_slave_regbank #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        SLAVE_CLK,
    input  logic        SLAVE_RST,
    input  logic [1:0]  SLAVE_WR_ADDR_ID,
    input  logic [31:0] SLAVE_WR_ADDR,
    input  logic [7:0]  SLAVE_WR_ADDR_LEN,
    input  logic [1:0]  SLAVE_WR_ADDR_BURST,
    input  logic        SLAVE_WR_ADDR_VALID,
    output logic        SLAVE_WR_ADDR_READY,
    input  logic [31:0] SLAVE_WR_DATA,
    input  logic [3:0]  SLAVE_WR_STRB,
    input  logic        SLAVE_WR_DATA_LAST,
    input  logic        SLAVE_WR_DATA_VALID,
    output logic        SLAVE_WR_DATA_READY,
    output logic [1:0]  SLAVE_WR_BACK_ID,
    output logic [1:0]  SLAVE_WR_BACK_RESP,
    output logic        SLAVE_WR_BACK_VALID,
    input  logic        SLAVE_WR_BACK_READY,
    input  logic [1:0]  SLAVE_RD_ADDR_ID,
    input  logic [31:0] SLAVE_RD_ADDR,
    input  logic [7:0]  SLAVE_RD_ADDR_LEN,
    input  logic [1:0]  SLAVE_RD_ADDR_BURST,
    input  logic        SLAVE_RD_ADDR_VALID,
    output logic        SLAVE_RD_ADDR_READY,
    output logic [1:0]  SLAVE_RD_BACK_ID,
    output logic [31:0] SLAVE_RD_DATA,
    output logic [1:0]  SLAVE_RD_DATA_RESP,
    output logic        SLAVE_RD_DATA_LAST,
    output logic        SLAVE_RD_DATA_VALID,
    input  logic        SLAVE_RD_DATA_READY
);

    localparam int unsigned DEPTH   = 1 << ADDR_WIDTH;
    localparam int unsigned IDX_TOP = ADDR_WIDTH + 2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
`ifdef AXI_SLAVE_WRAP_BURST_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, WR_DATA, WR_RESP, RD_DATA} state_t;

    state_t      state_q, state_d;
    logic [1:0]  id_q;
    logic [31:0] addr_q;
    logic [7:0]  len_q;
    logic [1:0]  burst_q;
    logic [8:0]  beat_q;
    logic [1:0]  resp_q;
    logic        prio_q;  // 0: write wins a tie, 1: read wins
    logic [31:0] rd_data_q;
    logic [1:0]  rd_resp_q;
    logic        rd_last_q;
    logic [31:0] mem [DEPTH];

    function automatic logic in_range(input logic [31:0] a);
        return a[31:IDX_TOP] == BASE_ADDR[31:IDX_TOP];
    endfunction

    function automatic logic wrap_ok(input logic [1:0] burst, input logic [7:0] len);
        return WRAP_EN && burst == BURST_WRAP &&
               (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
    endfunction

    function automatic logic burst_err(input logic [1:0] burst, input logic [7:0] len);
        case (burst)
            BURST_FIXED, BURST_INCR: return 1'b0;
            BURST_WRAP:              return !wrap_ok(burst, len);
            default:                 return 1'b1;
        endcase
    endfunction

    // Address of the following beat; unsupported WRAP falls back to INCR, reserved to FIXED.
    function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [1:0] burst,
                                              input logic [7:0] len);
        logic [31:0] inc;
        logic [31:0] mask;
        inc  = a + 32'd4;
        mask = {22'd0, len, 2'b11};
        if (wrap_ok(burst, len))
            return (a & ~mask) | (inc & mask);
        else if (burst == BURST_INCR || burst == BURST_WRAP)
            return inc;
        else
            return a;
    endfunction

    function automatic logic [1:0] beat_resp(input logic [31:0] a, input logic [1:0] burst,
                                             input logic [7:0] len);
        return (!in_range(a) || burst_err(burst, len)) ? RESP_SLVERR : RESP_OKAY;
    endfunction

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        return in_range(a) ? mem[a[IDX_TOP-1:2]] : 32'd0;
    endfunction

    logic idle, aw_grant, ar_grant, w_fire, r_fire, w_err, w_en;
    logic [ADDR_WIDTH-1:0] w_idx;

    assign idle     = (state_q == IDLE) && !SLAVE_RST;
    assign aw_grant = idle && SLAVE_WR_ADDR_VALID && (!SLAVE_RD_ADDR_VALID || !prio_q);
    assign ar_grant = idle && SLAVE_RD_ADDR_VALID && (!SLAVE_WR_ADDR_VALID || prio_q);
    assign w_fire   = (state_q == WR_DATA) && SLAVE_WR_DATA_VALID;
    assign r_fire   = (state_q == RD_DATA) && SLAVE_RD_DATA_READY;
    assign w_err    = beat_resp(addr_q, burst_q, len_q) != RESP_OKAY;
    assign w_en     = w_fire && !w_err && (beat_q <= {1'b0, len_q});
    assign w_idx    = addr_q[IDX_TOP-1:2];

    assign SLAVE_WR_ADDR_READY = aw_grant;
    assign SLAVE_RD_ADDR_READY = ar_grant;
    assign SLAVE_WR_DATA_READY = (state_q == WR_DATA);
    assign SLAVE_WR_BACK_VALID = (state_q == WR_RESP);
    assign SLAVE_RD_DATA_VALID = (state_q == RD_DATA);
    assign SLAVE_WR_BACK_ID    = id_q;
    assign SLAVE_WR_BACK_RESP  = resp_q;
    assign SLAVE_RD_BACK_ID    = id_q;
    assign SLAVE_RD_DATA       = rd_data_q;
    assign SLAVE_RD_DATA_RESP  = rd_resp_q;
    assign SLAVE_RD_DATA_LAST  = rd_last_q;

    always_ff @(posedge SLAVE_CLK or posedge SLAVE_RST) begin
        if (SLAVE_RST) state_q <= IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (aw_grant) state_d = WR_DATA;
                     else if (ar_grant) state_d = RD_DATA;
            WR_DATA: if (w_fire && SLAVE_WR_DATA_LAST) state_d = WR_RESP;
            WR_RESP: if (SLAVE_WR_BACK_READY) state_d = IDLE;
            RD_DATA: if (r_fire && rd_last_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Transaction context, beat sequencing and registered read channel.
    always_ff @(posedge SLAVE_CLK or posedge SLAVE_RST) begin
        if (SLAVE_RST) begin
            id_q      <= 2'd0;
            addr_q    <= 32'd0;
            len_q     <= 8'd0;
            burst_q   <= 2'd0;
            beat_q    <= 9'd0;
            resp_q    <= RESP_OKAY;
            prio_q    <= 1'b0;
            rd_data_q <= 32'd0;
            rd_resp_q <= RESP_OKAY;
            rd_last_q <= 1'b0;
        end else begin
            if (aw_grant) begin
                id_q    <= SLAVE_WR_ADDR_ID;
                addr_q  <= SLAVE_WR_ADDR;
                len_q   <= SLAVE_WR_ADDR_LEN;
                burst_q <= SLAVE_WR_ADDR_BURST;
                beat_q  <= 9'd0;
                resp_q  <= RESP_OKAY;
                prio_q  <= !prio_q;
            end else if (ar_grant) begin
                id_q      <= SLAVE_RD_ADDR_ID;
                addr_q    <= next_addr(SLAVE_RD_ADDR, SLAVE_RD_ADDR_BURST, SLAVE_RD_ADDR_LEN);
                len_q     <= SLAVE_RD_ADDR_LEN;
                burst_q   <= SLAVE_RD_ADDR_BURST;
                beat_q    <= 9'd0;
                resp_q    <= RESP_OKAY;
                prio_q    <= !prio_q;
                rd_data_q <= rd_word(SLAVE_RD_ADDR);
                rd_resp_q <= beat_resp(SLAVE_RD_ADDR, SLAVE_RD_ADDR_BURST, SLAVE_RD_ADDR_LEN);
                rd_last_q <= (SLAVE_RD_ADDR_LEN == 8'd0);
            end
            if (w_fire) begin
                addr_q <= next_addr(addr_q, burst_q, len_q);
                beat_q <= (&beat_q) ? beat_q : beat_q + 9'd1;
                if (w_err || (SLAVE_WR_DATA_LAST && beat_q != {1'b0, len_q}))
                    resp_q <= RESP_SLVERR;
            end
            if (r_fire && !rd_last_q) begin
                addr_q    <= next_addr(addr_q, burst_q, len_q);
                beat_q    <= beat_q + 9'd1;
                rd_data_q <= rd_word(addr_q);
                rd_resp_q <= beat_resp(addr_q, burst_q, len_q);
                rd_last_q <= (beat_q + 9'd1 == {1'b0, len_q});
            end
        end
    end

    // Word array is not reset; strobed byte writes only.
    always_ff @(posedge SLAVE_CLK) begin
        if (w_en) begin
            for (int b = 0; b < 4; b++) begin
                if (SLAVE_WR_STRB[b]) mem[w_idx][8*b +: 8] <= SLAVE_WR_DATA[8*b +: 8];
            end
        end
    end

endmodule
